// File: rtl/sram_controller.sv
// Memory-stage data port: each 32-bit word access becomes two 16-bit phases on an
// asynchronous SRAM, each WAIT_CYCLES long. The pipeline freezes while ready is low.
module sram_controller #(
    parameter int BASE_ADDR       = 1024,
    parameter int WAIT_CYCLES     = 2,
    parameter int SRAM_ADDR_WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic                       wr_en,
    input  logic [31:0]                address,
    input  logic [31:0]                write_data,
    output logic [31:0]                read_data,
    output logic                       ready,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [15:0]                sram_dq_out,
    input  logic [15:0]                sram_dq_in,
    output logic                       sram_dq_oe,
    output logic                       sram_we_n,
    output logic                       sram_oe_n
);
    localparam int         IW   = SRAM_ADDR_WIDTH - 1;
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    typedef struct packed {
        logic          is_wr;
        logic [IW-1:0] idx;
        logic [15:0]   wdata_hi;
    } req_t;

    state_t        state;
    logic [3:0]    cnt;
    req_t          req_q;
    logic          req, wr_only, last;
    logic [31:0]   offset;
    logic [IW-1:0] word_idx;
    logic          unused_offset_bits;

    assign req      = rd_en | wr_en;
    assign wr_only  = wr_en & ~rd_en;
    assign last     = (cnt == LAST);
    assign offset   = address - 32'(BASE_ADDR);
    // Bits above the SRAM size drop out, so out-of-range addresses wrap.
    assign word_idx = offset[IW+1:2];
    assign unused_offset_bits = ^{offset[31:IW+2], offset[1:0]};

    assign ready = (state == DONE) || ((state == IDLE) && !req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            req_q       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state          <= LOW;
                    cnt            <= '0;
                    req_q.is_wr    <= wr_only;
                    req_q.idx      <= word_idx;
                    req_q.wdata_hi <= write_data[31:16];
                    sram_addr      <= {word_idx, 1'b0};
                    sram_dq_out    <= write_data[15:0];
                    sram_dq_oe     <= wr_only;
                    sram_we_n      <= ~wr_only;
                    sram_oe_n      <= wr_only;
                end
                LOW: if (last) begin
                    state       <= HIGH;
                    cnt         <= '0;
                    sram_addr   <= {req_q.idx, 1'b1};
                    sram_dq_out <= req_q.wdata_hi;
                    if (!req_q.is_wr) read_data[15:0] <= sram_dq_in;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                HIGH: if (last) begin
                    state      <= DONE;
                    cnt        <= '0;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    if (!req_q.is_wr) read_data[31:16] <= sram_dq_in;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// Three controllers (W = 2, 1, 15) each driven by random and directed accesses; a per-instance
// monitor checks the SRAM bus and completions against a word-level reference model.
module tb_sram_controller;
    localparam int BASE = 1024;
    localparam int SAW  = 18;

    typedef struct {
        bit          is_rd;
        int          lo;
        logic [31:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] all_done;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input int w, input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL W=%0d %s: actual=%h required=%h", w, nm, act, exp);
        end
    endtask

    function automatic int word_key(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'(BASE)) >> 2;
        return int'(off & ((32'd1 << (SAW - 1)) - 32'd1));
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int W = (gi == 0) ? 2 : (gi == 1) ? 1 : 15;

        logic           rst, rd_en, wr_en, ready, sram_dq_oe, sram_we_n, sram_oe_n;
        logic [31:0]    address, write_data, read_data;
        logic [SAW-1:0] sram_addr;
        logic [15:0]    sram_dq_out, sram_dq_in;
        bit             done = 1'b0;

        exp_t           q[$];
        logic [31:0]    ref_mem[int];
        logic [15:0]    mem[int];

        sram_controller #(.WAIT_CYCLES(W)) u_dut (
            .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
            .address(address), .write_data(write_data), .read_data(read_data),
            .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
            .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
            .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
        );

        assign all_done[gi] = done;

        function automatic logic [15:0] mem_rd(input int a);
            return mem.exists(a) ? mem[a] : 16'h0;
        endfunction

        // Asynchronous SRAM: drive garbage whenever output enable is off.
        initial begin
            sram_dq_in = 16'h0;
            forever begin
                @(negedge clk);
                if (rst && !sram_we_n && sram_dq_oe) mem[int'(sram_addr)] = sram_dq_out;
                sram_dq_in = !sram_oe_n ? mem_rd(int'(sram_addr)) : 16'($urandom);
            end
        end

        task automatic push_exp(input bit rd, input logic [31:0] a, input logic [31:0] d);
            exp_t e;
            int   key;
            key   = word_key(a);
            e.is_rd = rd;
            e.lo    = key * 2;
            if (rd) e.data = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
            else begin
                e.data       = d;
                ref_mem[key] = d;
            end
            q.push_back(e);
        endtask

        task automatic wait_ready(input bit scr, input bit drp);
            bit ok;
            ok = 1'b0;
            for (int n = 0; n < 40 && !ok; n++) begin
                @(negedge clk);
                if (ready) ok = 1'b1;
                else if (n > 0) begin
                    if (scr) begin
                        address    = $urandom;
                        write_data = $urandom;
                    end
                    if (drp) begin
                        rd_en = 1'b0;
                        wr_en = 1'b0;
                    end
                end
            end
            if (!ok) chk(W, 1'b0, "ready_timeout", 32'(ready), 32'd1);
        endtask

        task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input bit scr, input bit drp);
            @(posedge clk); #1;
            rd_en = rd; wr_en = wr; address = a; write_data = d;
            push_exp(rd, a, d);
            wait_ready(scr, drp);
            rd_en = 1'b0; wr_en = 1'b0;
        endtask

        // Write, then keep the request high across DONE so a read follows immediately.
        task automatic back_to_back(input logic [31:0] a, input logic [31:0] d);
            @(posedge clk); #1;
            rd_en = 1'b0; wr_en = 1'b1; address = a; write_data = d;
            push_exp(1'b0, a, d);
            wait_ready(1'b0, 1'b0);
            rd_en = 1'b1; wr_en = 1'b0; write_data = $urandom;
            push_exp(1'b1, a, 32'h0);
            @(negedge clk);
            chk(W, !ready, "b2b_gap", 32'(ready), 32'd0);
            wait_ready(1'b0, 1'b0);
            rd_en = 1'b0;
        endtask

        initial begin
            rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
            repeat (3) @(posedge clk); #1 rst = 1'b1;

            access(0, 1, 32'd1024, 32'hDEADBEEF, 0, 0);
            access(1, 0, 32'd1024, 32'h0, 0, 0);
            access(0, 1, 32'd1036, 32'h12345678, 0, 0);
            access(1, 0, 32'd1036, 32'h0, 0, 0);
            access(1, 0, 32'd1038, 32'h0, 0, 0);
            access(1, 1, 32'd1036, 32'hFFFF0000, 0, 0);
            access(1, 0, 32'd1036, 32'h0, 0, 0);
            back_to_back(32'd1040, 32'hCAFEF00D);
            access(0, 1, 32'd1020, 32'hA5A55A5A, 1, 0);
            access(1, 0, 32'd1020, 32'h0, 0, 0);

            for (int i = 0; i < 40; i++) begin
                int          r;
                logic [31:0] a;
                r = $urandom_range(0, 9);
                a = (r == 8) ? 32'd1020 : 32'(BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3));
                if (r == 7) back_to_back(a, $urandom);
                else access(r < 4 || r == 9, r >= 4, a, $urandom, 1'($urandom), 1'($urandom));
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end

            // Abort a write in its high phase; the word is never read back.
            @(posedge clk); #1;
            wr_en = 1'b1; address = 32'(BASE + 4 * 200); write_data = $urandom;
            push_exp(1'b0, address, write_data);
            repeat (W + 1) @(posedge clk);
            #1 chk(W, !sram_we_n && sram_addr[0], "pre_reset_high_phase",
                   {30'h0, sram_addr[0], sram_we_n}, 32'd2);
            rst = 1'b0; wr_en = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            @(negedge clk);
            chk(W, ready, "post_reset_ready", 32'(ready), 32'd1);
            chk(W, read_data == 32'h0, "post_reset_read_data", read_data, 32'h0);

            access(1, 0, 32'd1024, 32'h0, 0, 0);
            done = 1'b1;
        end

        // Monitor: per-cycle bus checks during an access, completion checks when ready rises.
        initial begin
            bit          in_acc;
            int          k;
            logic [31:0] last_rd;
            exp_t        cur;
            bit          hi;
            in_acc  = 1'b0;
            k       = 0;
            last_rd = '0;
            cur     = '{is_rd: 1'b0, lo: 0, data: 32'h0};
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (in_acc && q.size() != 0) q.delete(0);
                    in_acc  = 1'b0;
                    k       = 0;
                    last_rd = '0;
                    chk(W, {sram_we_n, sram_oe_n, sram_dq_oe} == 3'b110 && sram_addr == '0 &&
                           sram_dq_out == 16'h0 && read_data == 32'h0, "reset_values",
                        {sram_dq_out, 10'(sram_addr), 3'b0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'h6);
                end else if (!ready) begin
                    if (!in_acc) begin
                        chk(W, q.size() != 0, "access_expected", 32'(q.size()), 32'd1);
                        if (q.size() != 0) cur = q[0];
                        in_acc = 1'b1;
                        k      = 0;
                        chk(W, {sram_we_n, sram_oe_n, sram_dq_oe} == 3'b110, "accept_strobes_idle",
                            {29'h0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'h6);
                    end else begin
                        hi = (k > W);
                        chk(W, int'(sram_addr) == cur.lo + int'(hi), "sram_addr",
                            32'(sram_addr), 32'(cur.lo + int'(hi)));
                        if (cur.is_rd)
                            chk(W, {sram_we_n, sram_oe_n, sram_dq_oe} == 3'b100, "read_strobes",
                                {29'h0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'h4);
                        else begin
                            chk(W, {sram_we_n, sram_oe_n, sram_dq_oe} == 3'b011, "write_strobes",
                                {29'h0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'h3);
                            chk(W, sram_dq_out == (hi ? cur.data[31:16] : cur.data[15:0]), "write_dq",
                                32'(sram_dq_out), 32'(hi ? cur.data[31:16] : cur.data[15:0]));
                        end
                    end
                    k++;
                end else if (in_acc) begin
                    if (q.size() != 0) q.delete(0);
                    chk(W, k == 2 * W + 1, "stall_length", 32'(k), 32'(2 * W + 1));
                    chk(W, {sram_we_n, sram_oe_n, sram_dq_oe} == 3'b110, "done_strobes_idle",
                        {29'h0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'h6);
                    if (cur.is_rd) begin
                        chk(W, read_data == cur.data, "read_data", read_data, cur.data);
                        last_rd = cur.data;
                    end else begin
                        chk(W, {mem_rd(cur.lo + 1), mem_rd(cur.lo)} == cur.data, "sram_word",
                            {mem_rd(cur.lo + 1), mem_rd(cur.lo)}, cur.data);
                        chk(W, read_data == last_rd, "read_data_hold", read_data, last_rd);
                    end
                    in_acc = 1'b0;
                end else begin
                    chk(W, {sram_we_n, sram_oe_n, sram_dq_oe} == 3'b110 && read_data == last_rd,
                        "idle", read_data, last_rd);
                end
            end
        end
    end

    initial begin
        int n;
        n = 0;
        while (all_done != 3'b111 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (all_done != 3'b111) chk(0, 1'b0, "global_timeout", 32'(all_done), 32'h7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
